// File: rtl/sdram_port_scheduler.sv
// Round-robin sequencer for the single SDRAM FIFO port (video fetch vs board).
// Ports: c0/c1 request bundles in, done/rdata/busy/grant out, FIFO ld/req/addr/data out.
module sdram_port_scheduler #(
  parameter int LOAD_WAIT = 8,
  parameter int SETTLE    = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c0_req,
  input  logic        c0_we,
  input  logic [24:0] c0_addr,
  input  logic [15:0] c0_wdata,
  input  logic        c1_req,
  input  logic        c1_we,
  input  logic [24:0] c1_addr,
  input  logic [15:0] c1_wdata,
  output logic        c0_done,
  output logic        c1_done,
  output logic        done_err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        grant,
  input  logic        wr_full,
  input  logic        rd_empty,
  input  logic [15:0] readdata,
  output logic        write_ld,
  output logic        write_req,
  output logic        read_ld,
  output logic        read_req,
  output logic [24:0] writeaddr,
  output logic [24:0] readaddr,
  output logic [15:0] writedata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DELAY,
    S_WAIT,
    S_ISSUE,
    S_TAIL
  } state_t;

  localparam logic [9:0] LW_END = 10'(LOAD_WAIT - 1);
  localparam logic [9:0] ST_END = 10'(SETTLE - 1);
  localparam logic [9:0] TO_END = 10'(TIMEOUT - 1);

  state_t      state;
  logic [9:0]  cnt;
  logic        last;
  logic        we_q;
  logic [24:0] addr_q;
  logic [15:0] wdata_q;

  logic        r0;
  logic        r1;
  logic        pick;
  logic        ready;
  logic        sel_we;
  logic [24:0] sel_addr;
  logic [15:0] sel_wdata;

  // A client finishing this cycle sits out, so the other one gets the port.
  assign r0 = c0_req & ~c0_done;
  assign r1 = c1_req & ~c1_done;
  assign pick = (r0 & r1) ? ~last : r1;

  assign sel_we    = pick ? c1_we : c0_we;
  assign sel_addr  = pick ? c1_addr : c0_addr;
  assign sel_wdata = pick ? c1_wdata : c0_wdata;

  assign ready = we_q ? ~wr_full : ~rd_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      grant     <= 1'b0;
      busy      <= 1'b0;
      c0_done   <= 1'b0;
      c1_done   <= 1'b0;
      done_err  <= 1'b0;
      rdata     <= '0;
      write_ld  <= 1'b0;
      write_req <= 1'b0;
      read_ld   <= 1'b0;
      read_req  <= 1'b0;
      writeaddr <= '0;
      readaddr  <= '0;
      writedata <= '0;
    end else begin
      write_ld  <= 1'b0;
      write_req <= 1'b0;
      read_ld   <= 1'b0;
      read_req  <= 1'b0;
      c0_done   <= 1'b0;
      c1_done   <= 1'b0;
      done_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (r0 | r1) begin
            grant   <= pick;
            last    <= pick;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            busy    <= 1'b1;
            cnt     <= '0;
            state   <= S_LOAD;
            if (sel_we) begin
              write_ld  <= 1'b1;
              writeaddr <= sel_addr;
            end else begin
              read_ld  <= 1'b1;
              readaddr <= sel_addr;
            end
          end
        end
        S_LOAD: begin
          cnt   <= '0;
          state <= S_DELAY;
        end
        S_DELAY: begin
          if (cnt == LW_END) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        S_WAIT: begin
          if (ready) begin
            cnt   <= '0;
            state <= S_ISSUE;
            if (we_q) begin
              write_req <= 1'b1;
              writedata <= wdata_q;
            end else begin
              read_req <= 1'b1;
            end
          end else if (cnt == TO_END) begin
            cnt      <= '0;
            busy     <= 1'b0;
            done_err <= 1'b1;
            c0_done  <= ~grant;
            c1_done  <= grant;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_TAIL;
        end
        S_TAIL: begin
          if (!we_q && cnt == '0) begin
            rdata <= readdata;
          end
          if (cnt == ST_END) begin
            cnt     <= '0;
            busy    <= 1'b0;
            c0_done <= ~grant;
            c1_done <= grant;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // addr_q is kept for debug visibility of the in-flight request.
  logic unused_ok;
  assign unused_ok = ^addr_q;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Bench for sdram_port_scheduler: cycle-offset reference model plus directed
// latency/arbitration/timeout/reset scenarios and a randomized phase.
module tb_sdram_port_scheduler;

  localparam int LW = 8;
  localparam int ST = 2;
  localparam int TO = 1023;

  logic        clk;
  logic        reset;
  logic        c0_req, c1_req, c0_we, c1_we;
  logic [24:0] c0_addr, c1_addr;
  logic [15:0] c0_wdata, c1_wdata;
  logic        c0_done, c1_done, done_err, busy, grant;
  logic [15:0] rdata;
  logic        wr_full, rd_empty;
  logic [15:0] readdata;
  logic        write_ld, write_req, read_ld, read_req;
  logic [24:0] writeaddr, readaddr;
  logic [15:0] writedata;

  sdram_port_scheduler dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we),
    .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c1_req(c1_req), .c1_we(c1_we),
    .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c0_done(c0_done), .c1_done(c1_done),
    .done_err(done_err), .rdata(rdata),
    .busy(busy), .grant(grant),
    .wr_full(wr_full), .rd_empty(rd_empty),
    .readdata(readdata),
    .write_ld(write_ld), .write_req(write_req),
    .read_ld(read_ld), .read_req(read_req),
    .writeaddr(writeaddr), .readaddr(readaddr),
    .writedata(writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
  endtask

  function automatic logic [90:0] dut_vec();
    return {write_ld, write_req, read_ld, read_req, c0_done, c1_done,
            done_err, busy, grant, writeaddr, readaddr, writedata, rdata};
  endfunction

  // Reference model: tracks the in-flight transaction by cycle offset k
  // from the grant (k=1 load, WAIT from k=LW+2, done SETTLE after issue).
  logic        e_wld, e_wreq, e_rld, e_rreq, e_d0, e_d1, e_err;
  logic        e_busy, e_grant;
  logic [24:0] e_waddr, e_raddr;
  logic [15:0] e_wdata, e_rdata;
  bit          m_act, m_we, pd0, pd1, r0, r1;
  int          m_k, m_iss, m_wn, m_cl, m_last;
  logic [24:0] m_addr;
  logic [15:0] m_wd;

  task automatic m_finish(input bit er);
    m_act  = 0;
    e_busy = 0;
    e_err  = er;
    if (m_cl == 1) e_d1 = 1; else e_d0 = 1;
  endtask

  initial begin
    {e_wld, e_wreq, e_rld, e_rreq, e_d0, e_d1, e_err, e_busy, e_grant} = '0;
    e_waddr = '0; e_raddr = '0; e_wdata = '0; e_rdata = '0;
    m_act = 0; m_last = 1;
  end

  always begin
    @(posedge clk);
    if (!reset) begin
      {e_wld, e_wreq, e_rld, e_rreq, e_d0, e_d1, e_err, e_busy, e_grant} = '0;
      e_waddr = '0; e_raddr = '0; e_wdata = '0; e_rdata = '0;
      m_act = 0; m_last = 1;
    end else begin
      pd0 = e_d0; pd1 = e_d1;
      {e_wld, e_wreq, e_rld, e_rreq, e_d0, e_d1, e_err} = '0;
      if (!m_act) begin
        r0 = c0_req && !pd0;
        r1 = c1_req && !pd1;
        if (r0 || r1) begin
          m_cl = (r0 && r1) ? 1 - m_last : (r1 ? 1 : 0);
          m_last = m_cl;
          e_grant = (m_cl == 1);
          m_we = (m_cl == 1) ? c1_we : c0_we;
          m_addr = (m_cl == 1) ? c1_addr : c0_addr;
          m_wd = (m_cl == 1) ? c1_wdata : c0_wdata;
          m_act = 1; m_k = 1; m_iss = -1; m_wn = 0;
          e_busy = 1;
          if (m_we) begin e_wld = 1; e_waddr = m_addr; end
          else begin e_rld = 1; e_raddr = m_addr; end
        end
      end else begin
        if (m_iss < 0) begin
          if (m_k >= LW + 2) begin
            m_wn++;
            if (m_we ? !wr_full : !rd_empty) begin
              m_iss = m_k + 1;
              if (m_we) begin e_wreq = 1; e_wdata = m_wd; end
              else e_rreq = 1;
            end else if (m_wn == TO) begin
              m_finish(1);
            end
          end
        end else begin
          if (m_k == m_iss + 1 && !m_we) e_rdata = readdata;
          if (m_k == m_iss + ST) m_finish(0);
        end
        m_k++;
      end
    end
    #1;
    chk("cycle_outputs", dut_vec(),
        {e_wld, e_wreq, e_rld, e_rreq, e_d0, e_d1, e_err, e_busy, e_grant,
         e_waddr, e_raddr, e_wdata, e_rdata});
  end

  task automatic do_reset();
    @(negedge clk);
    c0_req = 0; c1_req = 0; reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  task automatic txn(input bit c, input bit we, input logic [24:0] a,
                     input logic [15:0] d, input int stall,
                     output int t_ld, output int t_req, output int t_done,
                     output bit err, output logic [24:0] a_ld,
                     output logic [15:0] d_req, output logic [15:0] rd12,
                     output logic [15:0] rd13, output int wrong);
    int n;
    bit nr;
    t_ld = -1; t_req = -1; t_done = -1; err = 0; wrong = 0;
    a_ld = '0; d_req = '0; rd12 = '0; rd13 = '0;
    @(negedge clk);
    nr = (stall > 0);
    wr_full = nr; rd_empty = nr;
    if (c) begin c1_req = 1; c1_we = we; c1_addr = a; c1_wdata = d; end
    else begin c0_req = 1; c0_we = we; c0_addr = a; c0_wdata = d; end
    n = 0;
    while (t_done < 0 && n < 3000) begin
      @(posedge clk); #1; n++;
      if ((we ? write_ld : read_ld) && t_ld < 0) begin
        t_ld = n; a_ld = we ? writeaddr : readaddr;
      end
      if ((we ? write_req : read_req) && t_req < 0) begin
        t_req = n; d_req = writedata;
      end
      if (we ? (read_ld | read_req) : (write_ld | write_req)) wrong++;
      if (n == 12) rd12 = rdata;
      if (n == 13) rd13 = rdata;
      if (c ? c1_done : c0_done) begin t_done = n; err = done_err; end
      @(negedge clk);
      nr = (stall > 0) && (n < LW + 2 + stall);
      wr_full = nr; rd_empty = nr;
    end
    chk("txn_bound", t_done >= 0, 1);
    if (c) c1_req = 0; else c0_req = 0;
  endtask

  int w_who[8], w_when[8], w_err[8];
  int w_wreq;

  task automatic watch(input int nd);
    int n, got;
    n = 0; got = 0; w_wreq = 0;
    while (got < nd && n < 3000) begin
      @(posedge clk); #1; n++;
      if (write_req) w_wreq++;
      if ((c0_done || c1_done) && got < 8) begin
        w_who[got] = c1_done ? 1 : 0;
        w_when[got] = n;
        w_err[got] = int'(done_err);
        got++;
      end
    end
    chk("watch_bound", got, nd);
  endtask

  int t_ld, t_req, t_done, wrong, nd;
  bit err;
  logic [24:0] a_ld;
  logic [15:0] d_req, rd12, rd13;
  bit pend[2];
  int k;

  initial begin
    reset = 0;
    c0_req = 0; c1_req = 0; c0_we = 0; c1_we = 0;
    c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
    wr_full = 0; rd_empty = 0; readdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", dut_vec(), 91'd0);
    reset = 1;

    txn(1, 1, 25'h3, 16'h00FF, 0, t_ld, t_req, t_done, err,
        a_ld, d_req, rd12, rd13, wrong);
    chk("wr_ld_cycle", t_ld, 1);
    chk("wr_addr", a_ld, 25'h3);
    chk("wr_req_cycle", t_req, 11);
    chk("wr_data", d_req, 16'h00FF);
    chk("wr_done_cycle", t_done, 14);
    chk("wr_err", err, 0);
    chk("wr_side_only", wrong, 0);

    readdata = 16'hA5A5;
    txn(0, 0, 25'h0, 16'h0, 0, t_ld, t_req, t_done, err,
        a_ld, d_req, rd12, rd13, wrong);
    chk("rd_ld_cycle", t_ld, 1);
    chk("rd_req_cycle", t_req, 11);
    chk("rd_before_capture", rd12, 16'h0);
    chk("rd_capture", rd13, 16'hA5A5);
    chk("rd_done_cycle", t_done, 14);
    chk("rd_err", err, 0);
    chk("rd_side_only", wrong, 0);

    readdata = 16'h1234;
    txn(0, 0, 25'h1ABCDEF, 16'h0, 20, t_ld, t_req, t_done, err,
        a_ld, d_req, rd12, rd13, wrong);
    chk("stall_req_cycle", t_req, 31);
    chk("stall_done_cycle", t_done, 34);
    chk("stall_err", err, 0);

    do_reset();
    @(negedge clk);
    c0_we = 0; c1_we = 0; c0_addr = 25'h10; c1_addr = 25'h20;
    c0_req = 1; c1_req = 1;
    watch(4);
    chk("cont_who0", w_who[0], 0); chk("cont_when0", w_when[0], 14);
    chk("cont_who1", w_who[1], 1); chk("cont_when1", w_when[1], 28);
    chk("cont_who2", w_who[2], 0); chk("cont_when2", w_when[2], 42);
    chk("cont_who3", w_who[3], 1); chk("cont_when3", w_when[3], 56);

    do_reset();
    @(negedge clk);
    wr_full = 1; rd_empty = 0;
    c0_we = 1; c0_addr = 25'h5; c0_wdata = 16'h7;
    c1_we = 0; c1_addr = 25'h9;
    c0_req = 1; c1_req = 1;
    watch(2);
    chk("to_who", w_who[0], 0);
    chk("to_when", w_when[0], 10 + TO);
    chk("to_err", w_err[0], 1);
    chk("to_no_wreq", w_wreq, 0);
    chk("to_next_who", w_who[1], 1);
    chk("to_next_when", w_when[1], 24 + TO);
    chk("to_next_err", w_err[1], 0);

    do_reset();
    @(negedge clk);
    wr_full = 0; rd_empty = 0; readdata = 16'hBEEF;
    c0_we = 0; c0_addr = 25'h55; c0_req = 1;
    repeat (12) begin @(posedge clk); #1; end
    chk("tail_busy", busy, 1);
    @(negedge clk);
    reset = 0;
    c1_we = 0; c1_addr = 25'h66; c1_req = 1;
    #1;
    chk("async_clear", dut_vec(), 91'd0);
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (c0_done || c1_done) nd++;
    end
    chk("no_done_in_reset", nd, 0);
    @(negedge clk);
    reset = 1;
    watch(2);
    chk("post_rst_who0", w_who[0], 0);
    chk("post_rst_when0", w_when[0], 14);
    chk("post_rst_who1", w_who[1], 1);
    chk("post_rst_when1", w_when[1], 28);

    do_reset();
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pend[0] && c0_done) begin pend[0] = 0; c0_req = 0; end
      if (pend[1] && c1_done) begin pend[1] = 0; c1_req = 0; end
      if (!pend[0] && $urandom_range(0, 3) == 0) begin
        pend[0] = 1; c0_req = 1; c0_we = 1'($urandom);
        c0_addr = 25'($urandom); c0_wdata = 16'($urandom);
      end
      if (!pend[1] && $urandom_range(0, 3) == 0) begin
        pend[1] = 1; c1_req = 1; c1_we = 1'($urandom);
        c1_addr = 25'($urandom); c1_wdata = 16'($urandom);
      end
      wr_full = ($urandom_range(0, 9) < 3);
      rd_empty = ($urandom_range(0, 9) < 3);
      readdata = 16'($urandom);
    end
    k = 0;
    while ((pend[0] || pend[1]) && k < 500) begin
      @(negedge clk); k++;
      wr_full = 0; rd_empty = 0;
      if (pend[0] && c0_done) begin pend[0] = 0; c0_req = 0; end
      if (pend[1] && c1_done) begin pend[1] = 0; c1_req = 0; end
    end
    chk("drain", {pend[0], pend[1]}, 2'b00);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
